// File: rtl/light_scheduler_pkg.sv
// Shared constants and FSM state encodings for the room lighting scheduler.
package light_scheduler_pkg;

  localparam int unsigned DAYLIGHT_SENSOR_DATA_WIDTH = 8;
  localparam int unsigned MOTION_SENSOR_DATA_WIDTH   = 1;
  localparam int unsigned LIGHT_THRESHOLD            = 100;
  localparam int unsigned LIGHT_HOLD_TICKS           = 1000;

  typedef enum logic [1:0] {
    LS_IDLE     = 2'd0,
    LS_ON       = 2'd1,
    LS_HOLD     = 2'd2,
    LS_OVERRIDE = 2'd3
  } ls_state_e;

endpackage

// File: rtl/light_hold_timer.sv
// Hold-off counter: loads HOLD_TICKS, counts qualified ticks down, flags the final tick.
module light_hold_timer #(
  parameter int unsigned HOLD_TICKS = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

  logic [CNT_W-1:0] cnt;

  // Saturating down-counter; never wraps below zero
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD_TICKS);
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign expire = tick && (cnt == CNT_W'(1));

endmodule

// File: rtl/light_scheduler.sv
// Lamp sequencer: hysteresis darkness flag plus IDLE/ON/HOLD/OVERRIDE FSM.
// Manual override is built only when LIGHTS_MANUAL_OVERRIDE_EN is defined.
module light_scheduler
  import light_scheduler_pkg::*;
#(
  parameter int unsigned DAYLIGHT_W = DAYLIGHT_SENSOR_DATA_WIDTH,
  parameter int unsigned THRESHOLD  = LIGHT_THRESHOLD,
  parameter int unsigned HYST       = 4,
  parameter int unsigned HOLD_TICKS = LIGHT_HOLD_TICKS
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [DAYLIGHT_W-1:0]               daylight,
  input  logic [MOTION_SENSOR_DATA_WIDTH-1:0] presence,
  input  logic                                tick,
  input  logic                                override_en,
  input  logic                                override_val,
  output logic                                lights,
  output logic [1:0]                          state,
  output logic                                dark
);

  localparam logic [DAYLIGHT_W-1:0] DARK_LVL   = DAYLIGHT_W'(THRESHOLD);
  localparam logic [DAYLIGHT_W:0]   BRIGHT_LVL = (DAYLIGHT_W + 1)'(THRESHOLD + HYST);

  ls_state_e state_q, state_d;
  logic      lights_d;
  logic      pres;
  logic      ovr;
  logic      load, clear, expire;

  assign pres = |presence;

`ifdef LIGHTS_MANUAL_OVERRIDE_EN
  assign ovr = override_en;
`else
  assign ovr = 1'b0;
  logic unused_override;
  assign unused_override = &{1'b0, override_en, override_val};
`endif

  // Darkness flag with hysteresis band [THRESHOLD, THRESHOLD+HYST)
  always_ff @(posedge clk) begin
    if (rst) begin
      dark <= 1'b0;
    end else if (daylight < DARK_LVL) begin
      dark <= 1'b1;
    end else if ({1'b0, daylight} >= BRIGHT_LVL) begin
      dark <= 1'b0;
    end
  end

  light_hold_timer #(
    .HOLD_TICKS(HOLD_TICKS)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .clear (clear),
    .tick  (tick && (state_q == LS_HOLD)),
    .expire(expire)
  );

  always_comb begin
    state_d  = state_q;
    lights_d = 1'b0;
    load     = 1'b0;
    clear    = 1'b0;
    case (state_q)
      LS_IDLE: begin
        if (ovr)               state_d = LS_OVERRIDE;
        else if (dark && pres) state_d = LS_ON;
      end
      LS_ON: begin
        if (ovr)        state_d = LS_OVERRIDE;
        else if (!dark) state_d = LS_IDLE;
        else if (!pres) begin
          state_d = LS_HOLD;
          load    = 1'b1;
        end
      end
      LS_HOLD: begin
        // Presence outranks expiry, darkness loss outranks presence
        clear = 1'b1;
        if (ovr)         state_d = LS_OVERRIDE;
        else if (!dark)  state_d = LS_IDLE;
        else if (pres)   state_d = LS_ON;
        else if (expire) state_d = LS_IDLE;
        else             clear   = 1'b0;
      end
`ifdef LIGHTS_MANUAL_OVERRIDE_EN
      LS_OVERRIDE: begin
        if (!ovr) begin
          state_d = LS_IDLE;
          clear   = 1'b1;
        end
      end
`endif
      default: state_d = LS_IDLE;
    endcase

    case (state_d)
      LS_ON, LS_HOLD: lights_d = 1'b1;
`ifdef LIGHTS_MANUAL_OVERRIDE_EN
      LS_OVERRIDE:    lights_d = override_val;
`endif
      default:        lights_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LS_IDLE;
      lights  <= 1'b0;
    end else begin
      state_q <= state_d;
      lights  <= lights_d;
    end
  end

  assign state = state_q;

endmodule
